// File: rtl/smac_pkg.sv
// Shared definitions for the sequential signed multiply-accumulate block.
// Holds operand/product widths, the Booth iteration count, the control FSM
// state encoding and the radix-2 Booth recoding of the multiplier bit pair.
package smac_pkg;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned PROD_W  = 2 * WIDTH;
    localparam int unsigned BOOTH_W = 2 * WIDTH + 1;
    localparam int unsigned ITERS   = 16;
    // Counter must be able to hold ITERS itself (the finalise marker).
    localparam int unsigned CNT_W   = $clog2(ITERS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLdb,
        StLdc,
        StCalc,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        BoothNone,
        BoothAdd,
        BoothSub
    } booth_op_e;

    // Radix-2 Booth: {P[1], P[0]} = 01 -> +A, 10 -> -A, 00/11 -> nothing.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        case (pair)
            2'b01:   op = BoothAdd;
            2'b10:   op = BoothSub;
            default: op = BoothNone;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/smac_booth_step.sv
// One radix-2 Booth iteration (combinational).
// Ports:
//   p_i  [32:0]  current Booth register {acc[15:0], multiplier[15:0], guard}
//   a_i  [15:0]  multiplicand
//   p_o  [32:0]  register after add/sub/none and a 1-bit arithmetic shift
module smac_booth_step
    import smac_pkg::*;
(
    input  logic [BOOTH_W-1:0] p_i,
    input  logic [WIDTH-1:0]   a_i,
    output logic [BOOTH_W-1:0] p_o
);

    logic [WIDTH:0] acc_ext;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        // 17-bit add keeps -A exact for A = 0x8000 and the sum never wraps.
        acc_ext = {p_i[BOOTH_W-1], p_i[BOOTH_W-1 -: WIDTH]};
        a_ext   = {a_i[WIDTH-1], a_i};
        sum     = acc_ext;
        case (booth_decode(p_i[1:0]))
            BoothAdd: sum = acc_ext + a_ext;
            BoothSub: sum = acc_ext - a_ext;
            default:  sum = acc_ext;
        endcase
        // Arithmetic shift right: the 17-bit sum supplies the new sign bit.
        p_o = {sum, p_i[WIDTH:1]};
    end

endmodule

// File: rtl/smac.sv
// Sequential signed multiply-accumulate: product = A * B + sext(C).
// Operands arrive on a shared 16-bit bus (A with start, then B, then C),
// followed by 16 Booth iterations and a final accumulate cycle.
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   st_i              start, sampled only when idle or done
//   dbus_i    [15:0]  operand bus
//   product_o [31:0]  registered signed result
//   rdy_o             registered result-valid flag
module smac
    import smac_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              st_i,
    input  logic [WIDTH-1:0]  dbus_i,
    output logic [PROD_W-1:0] product_o,
    output logic              rdy_o
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    c_q, c_d;
    logic [BOOTH_W-1:0]  p_q, p_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                rdy_q, rdy_d;
    logic [BOOTH_W-1:0]  p_step;

    smac_booth_step u_booth_step (
        .p_i (p_q),
        .a_i (a_q),
        .p_o (p_step)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        rdy_d     = rdy_q;
        case (state_q)
            StIdle, StDone: begin
                if (st_i) begin
                    a_d     = dbus_i;
                    rdy_d   = 1'b0;
                    state_d = StLdb;
                end
            end
            StLdb: begin
                b_d     = dbus_i;
                state_d = StLdc;
            end
            StLdc: begin
                c_d     = dbus_i;
                p_d     = {{WIDTH{1'b0}}, b_q, 1'b0};
                cnt_d   = '0;
                state_d = StCalc;
            end
            StCalc: begin
                // Counter reaching ITERS marks the extra accumulate cycle, which
                // places the Rdy rise 19 edges after the start edge.
                if (cnt_q == CNT_W'(ITERS)) begin
                    product_d = p_q[BOOTH_W-1:1] + {{WIDTH{c_q[WIDTH-1]}}, c_q};
                    rdy_d     = 1'b1;
                    state_d   = StDone;
                end else begin
                    p_d   = p_step;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            rdy_q     <= rdy_d;
        end
    end

    assign product_o = product_q;
    assign rdy_o     = rdy_q;

endmodule
